// File: rtl/text_console_ctrl.sv
// text_console_ctrl: character-cell text console with a clearing FSM, cursor control and a video read port
// Parameters: COLS / ROWS (screen size in 16x16 cells), BLINK_FRAMES (frames per cursor blink half-period)
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   px, py, frame_start             pixel position and one-cycle pulse at the start of each frame
//   wr_valid, wr_ready, wr_char     character write handshake (ASCII code)
//   ascii_value, loc_x, loc_y       registered glyph code and cell origin for the renderer
//   cursor_col, cursor_row, busy    cursor position and screen-clear-in-progress flag
module text_console_ctrl #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic       frame_start,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] wr_char,
  output logic [6:0] ascii_value,
  output logic [9:0] loc_x,
  output logic [9:0] loc_y,
  output logic [5:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);
  localparam int N = COLS * ROWS;
  localparam int IW = (N > 2048) ? $clog2(N) : 11;
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] clr_q, clr_d;
  logic [5:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic blink_q;
  logic [FW-1:0] frm_q;
  logic [6:0] ascii_q;
  logic [9:0] loc_x_q, loc_y_q;
  logic [6:0] mem_q [N];
  logic we;
  logic [IW-1:0] waddr;
  logic [6:0] wdata;
  logic [IW-1:0] cur_idx, rd_idx;
  logic [4:0] row_inc;
  logic in_rng, cur_hit, frm_last;
  assign cur_idx = IW'(row_q) * IW'(COLS) + IW'(col_q);
  assign rd_idx = IW'(py[9:4]) * IW'(COLS) + IW'(px[9:4]);
  assign row_inc = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
  assign in_rng = (32'(px) < COLS * 16) && (32'(py) < ROWS * 16);
  assign cur_hit = blink_q && (state_q == IDLE) && (px[9:4] == col_q) && (py[9:4] == {1'b0, row_q});
  assign frm_last = frm_q == FW'(BLINK_FRAMES - 1);
  always_comb begin
    state_d = state_q;
    clr_d = clr_q;
    col_d = col_q;
    row_d = row_q;
    we = 1'b0;
    waddr = cur_idx;
    wdata = wr_char;
    if (state_q == CLEAR) begin
      we = 1'b1;
      waddr = clr_q;
      wdata = 7'h20;
      clr_d = clr_q + IW'(1);
      if (clr_q == IW'(N - 1)) begin
        state_d = IDLE;
        col_d = 6'd0;
        row_d = 5'd0;
      end
    end else if (wr_valid) begin
      if (wr_char >= 7'h20 && wr_char != 7'h7F) begin
        we = 1'b1;
        col_d = (col_q == 6'(COLS - 1)) ? 6'd0 : col_q + 6'd1;
        row_d = (col_q == 6'(COLS - 1)) ? row_inc : row_q;
      end else if (wr_char == 7'h0A) begin
        col_d = 6'd0;
        row_d = row_inc;
      end else if (wr_char == 7'h0D) begin
        col_d = 6'd0;
      end else if (wr_char == 7'h08 && col_q != 6'd0) begin
        // backspace erases the cell it moves onto
        we = 1'b1;
        waddr = cur_idx - IW'(1);
        wdata = 7'h20;
        col_d = col_q - 6'd1;
      end else if (wr_char == 7'h0C) begin
        // cursor keeps its position until the clear finishes
        state_d = CLEAR;
        clr_d = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_q <= '0;
      col_q <= 6'd0;
      row_q <= 5'd0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q <= 1'b1;
      frm_q <= '0;
    end else if (frame_start) begin
      frm_q <= frm_last ? '0 : frm_q + FW'(1);
      blink_q <= blink_q ^ frm_last;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  // the read samples mem_q before this edge's write lands, giving read-first behaviour
  always_ff @(posedge clk) begin
    if (rst) begin
      ascii_q <= 7'h20;
      loc_x_q <= 10'd0;
      loc_y_q <= 10'd0;
    end else begin
      ascii_q <= !in_rng ? 7'h20 : cur_hit ? 7'h5F : mem_q[in_rng ? rd_idx : '0];
      loc_x_q <= {px[9:4], 4'b0000};
      loc_y_q <= {py[9:4], 4'b0000};
    end
  end
  assign wr_ready = state_q == IDLE;
  assign busy = state_q == CLEAR;
  assign ascii_value = ascii_q;
  assign loc_x = loc_x_q;
  assign loc_y = loc_y_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
endmodule

// File: tb/tb_text_console_ctrl.sv
// tb_text_console_ctrl: directed scoreboard bench for text_console_ctrl
module tb_text_console_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] px = '0, py = '0;
  logic frame_start = 1'b0, wr_valid = 1'b0;
  logic [6:0] wr_char = '0;
  logic wr_ready, busy;
  logic [6:0] ascii_value;
  logic [9:0] loc_x, loc_y;
  logic [5:0] cursor_col;
  logic [4:0] cursor_row;
  text_console_ctrl dut (
    .clk(clk), .rst(rst), .px(px), .py(py), .frame_start(frame_start),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_char(wr_char),
    .ascii_value(ascii_value), .loc_x(loc_x), .loc_y(loc_y),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic [6:0] mm [1200];
  int cc = 0, cr = 0, fcnt = 0;
  bit blink_m = 1'b1;
  typedef struct {logic [6:0] a; logic [9:0] lx; logic [9:0] ly;} exp_t;
  exp_t sb[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [6:0] vexp(input logic [9:0] x, input logic [9:0] y);
    int c = int'(x) >> 4;
    int r = int'(y) >> 4;
    if (int'(x) >= 640 || int'(y) >= 480) return 7'h20;
    if (c == cc && r == cr && blink_m) return 7'h5F;
    return mm[r * 40 + c];
  endfunction
  task automatic adv_row();
    cr = (cr == 29) ? 0 : cr + 1;
  endtask
  task automatic mdl(input logic [6:0] ch);
    if (ch >= 7'h20 && ch != 7'h7F) begin
      mm[cr * 40 + cc] = ch;
      if (cc == 39) begin cc = 0; adv_row(); end else cc++;
    end else if (ch == 7'h0A) begin
      cc = 0;
      adv_row();
    end else if (ch == 7'h0D) begin
      cc = 0;
    end else if (ch == 7'h08 && cc > 0) begin
      cc--;
      mm[cr * 40 + cc] = 7'h20;
    end else if (ch == 7'h0C) begin
      for (int i = 0; i < 1200; i++) mm[i] = 7'h20;
      cc = 0;
      cr = 0;
    end
  endtask
  task automatic push_exp(input logic [9:0] x, input logic [9:0] y);
    exp_t e;
    e.a = vexp(x, y);
    e.lx = {x[9:4], 4'b0000};
    e.ly = {y[9:4], 4'b0000};
    sb.push_back(e);
  endtask
  task automatic pop_chk(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_ascii"}, 32'(ascii_value), 32'(e.a));
    chk({tag, "_loc_x"}, 32'(loc_x), 32'(e.lx));
    chk({tag, "_loc_y"}, 32'(loc_y), 32'(e.ly));
  endtask
  task automatic rd(input string tag, input logic [9:0] x, input logic [9:0] y);
    px = x;
    py = y;
    push_exp(x, y);
    step();
    pop_chk(tag);
  endtask
  task automatic wr(input logic [6:0] ch);
    chk("wr_ready", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_char = ch;
    step();
    wr_valid = 1'b0;
    mdl(ch);
  endtask
  task automatic wrrd(input string tag, input logic [6:0] ch, input logic [9:0] x, input logic [9:0] y);
    px = x;
    py = y;
    push_exp(x, y);
    wr_valid = 1'b1;
    wr_char = ch;
    step();
    wr_valid = 1'b0;
    mdl(ch);
    pop_chk(tag);
  endtask
  task automatic chk_cur(input string tag, input int c, input int r);
    chk({tag, "_col"}, 32'(cursor_col), 32'(c));
    chk({tag, "_row"}, 32'(cursor_row), 32'(r));
  endtask
  task automatic frames(input int n);
    repeat (n) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
      fcnt++;
      if (fcnt == 32) begin
        fcnt = 0;
        blink_m = ~blink_m;
      end
    end
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (!wr_ready && n < 3000) begin
      n++;
      step();
    end
  endtask
  initial begin
    int n;
    for (int i = 0; i < 1200; i++) mm[i] = 7'h20;
    wr_valid = 1'b1;
    wr_char = 7'h51;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_ascii", 32'(ascii_value), 32'h20);
    chk("rst_loc_x", 32'(loc_x), 32'd0);
    chk("rst_loc_y", 32'(loc_y), 32'd0);
    chk_cur("rst_cursor", 0, 0);
    rst = 1'b0;
    repeat (500) step();
    chk("mid_clear_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready(n);
    wr_valid = 1'b0;
    chk("clear_len", 32'(n), 32'd1200);
    chk("clear_done_busy", 32'(busy), 32'd0);
    chk_cur("clear_cursor", 0, 0);
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++)
        rd("scan", 10'(c * 16 + $urandom_range(15)), 10'(r * 16 + $urandom_range(15)));
    chk_cur("no_accept_in_clear", 0, 0);
    wr(7'h41);
    chk_cur("after_A", 1, 0);
    for (int x = 0; x < 16; x++) rd("cell0_A", 10'(x), 10'd0);
    rd("cell0_A_low", 10'd7, 10'd15);
    wr(7'h0D);
    repeat (29) wr(7'h0A);
    chk_cur("lf29", 0, 29);
    repeat (39) wr(7'h2E);
    chk_cur("last_col", 39, 29);
    wr(7'h5A);
    chk_cur("wrap", 0, 0);
    rd("cell1199", 10'd624, 10'd464);
    rd("cell1198", 10'd608, 10'd470);
    wr(7'h08);
    chk_cur("bs_col0", 0, 0);
    wr(7'h48);
    wr(7'h49);
    wr(7'h08);
    chk_cur("hi_bs", 1, 0);
    rd("cell0_H", 10'd3, 10'd3);
    wr(7'h0D);
    wr(7'h0A);
    chk_cur("cr_lf", 0, 1);
    wr(7'h00);
    wr(7'h7F);
    wr(7'h1B);
    chk_cur("ignored", 0, 1);
    rd("oor_x", 10'd640, 10'd0);
    rd("oor_y", 10'd0, 10'd480);
    rd("oor_max", 10'd1023, 10'd1023);
    rd("edge_in", 10'd639, 10'd479);
    rd("blink_on", 10'd0, 10'd16);
    frames(31);
    rd("blink_31", 10'd0, 10'd16);
    frames(1);
    rd("blink_off", 10'd0, 10'd16);
    rd("cell1_space", 10'd16, 10'd0);
    frames(32);
    rd("blink_back", 10'd5, 10'd20);
    frames(32);
    wrrd("read_first", 7'h56, 10'd0, 10'd16);
    rd("after_write", 10'd0, 10'd16);
    chk_cur("after_V", 1, 1);
    wr(7'h57);
    wr(7'h58);
    chk_cur("pre_ff", 3, 1);
    chk("wr_ready_pre_ff", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_char = 7'h0C;
    step();
    wr_char = 7'h58;
    mdl(7'h0C);
    repeat (10) step();
    chk("ff_busy", 32'(busy), 32'd1);
    chk_cur("ff_hold", 3, 1);
    wait_ready(n);
    wr_valid = 1'b0;
    chk("ff_clear_len", 32'(n + 10), 32'd1200);
    chk_cur("ff_done", 0, 0);
    step();
    chk_cur("ff_no_extra", 0, 0);
    rd("ff_cell_V", 10'd0, 10'd16);
    rd("ff_cell_W", 10'd32, 10'd16);
    rd("ff_cell0", 10'd0, 10'd0);
    rd("ff_cell1199", 10'd630, 10'd470);
    wr(7'h4B);
    rd("post_ff_K", 10'd0, 10'd0);
    chk_cur("post_ff", 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/text_console_ctrl.md
TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

Interface
REQ-001 SHALL have parameters: COLS, 40, character columns; ROWS, 30, character rows; BLINK_FRAMES, 32, frames per cursor blink half-period.
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: px  in  10  pixel x; py  in  10  pixel y; frame_start  in  1  one-cycle pulse per frame.
REQ-004 SHALL have ports: wr_valid  in  1  char offered; wr_ready  out  1  char accepted when both high; wr_char  in  7  ASCII code.
REQ-005 SHALL have ports: ascii_value  out  7  code for glyph renderer; loc_x  out  10  cell origin x; loc_y  out  10  cell origin y.
REQ-006 SHALL have ports: cursor_col  out  6  cursor column; cursor_row  out  5  cursor row; busy  out  1  clear in progress.

Function
REQ-007 SHALL hold a COLS*ROWS x 7-bit text buffer, cell index = row*COLS + col; one write port, one video read port.
REQ-008 SHALL implement states CLEAR and IDLE; wr_ready = 1 only in IDLE; busy = 1 only in CLEAR.
REQ-009 CLEAR SHALL write 0x20 to one cell per cycle, index 0 to COLS*ROWS-1, then set cursor (0,0) and enter IDLE on the next cycle.
REQ-010 In IDLE a handshake SHALL take effect in one cycle; at most one char accepted per cycle.
REQ-011 Printable 0x20-0x7E SHALL be written at the cursor, then the cursor advances one column.
REQ-012 Column advance from COLS-1 SHALL go to column 0 and row+1; row advance from ROWS-1 SHALL wrap to row 0 (no scroll).
REQ-013 0x0A SHALL set column 0 and advance row per REQ-012; 0x0D SHALL set column 0 only.
REQ-014 0x08 SHALL, if column>0, decrement column and write 0x20 at the new position; at column 0 it SHALL have no effect.
REQ-015 0x0C SHALL enter CLEAR on the next cycle; cursor holds until CLEAR completes.
REQ-016 All other codes 0x00-0x1F and 0x7F SHALL be accepted and ignored.
REQ-017 Video read index SHALL be (py>>4)*COLS + (px>>4); ascii_value, loc_x, loc_y SHALL be registered with 1-cycle latency from px/py.
REQ-018 loc_x SHALL be {px[9:4],4'b0000}; loc_y SHALL be {py[9:4],4'b0000}.
REQ-019 If px >= COLS*16 or py >= ROWS*16, ascii_value SHALL be 0x20 (no buffer read used).
REQ-020 Simultaneous write and video read of the same cell SHALL return the old contents (read-first).
REQ-021 blink_on SHALL toggle after every BLINK_FRAMES frame_start pulses; frame counter wraps to 0 on toggle.
REQ-022 When the read cell equals the cursor cell, blink_on = 1 and state is IDLE, ascii_value SHALL be 0x5F.
REQ-023 Index arithmetic SHALL be at least 11 bits, no truncation for COLS*ROWS <= 2048.

Reset
REQ-024 rst SHALL set state CLEAR with clear index 0, cursor (0,0), blink_on 1, frame counter 0, ascii_value 0x20, loc_x 0, loc_y 0, wr_ready 0, busy 1.
REQ-025 rst asserted during CLEAR SHALL restart clearing from index 0.
REQ-026 wr_valid during rst or CLEAR SHALL be ignored; wr_ready SHALL first rise COLS*ROWS+1 cycles after rst deasserts.

Verification
REQ-027 Reset, count cycles -> busy high 1200 cycles, wr_ready rises cycle 1201, cursor (0,0), all cells read 0x20.
REQ-028 Write 'A' (0x41) at (0,0), scan px=0..15, py=0 -> ascii_value 0x41 one cycle later (blink off), cursor (1,0).
REQ-029 Cursor (39,29), write 'Z' -> cell 1199 = 0x5A, cursor wraps to (0,0); then 0x08 at col 0 -> cursor unchanged.
REQ-030 Write 'H','I',0x08 -> cursor (1,0), cell 1 = 0x20; write 0x0D then 0x0A -> cursor (0,1).
REQ-031 Write 0x0C mid-screen, hold wr_valid -> wr_ready low 1200 cycles, no extra char accepted, cursor (0,0) after.
REQ-032 px=640,py=0 -> ascii_value 0x20; 32 frame_start pulses -> blink_on toggles, cursor cell shows 0x5F only when on.
